// File: rtl/arena_transition_controller.sv
// Arena box transition controller: accepts a target box/gravity command, walks the four
// box edges toward the target at a programmable step rate, then applies the new gravity.
module arena_transition_controller #(
    parameter int DEFAULT_X0 = 200,
    parameter int DEFAULT_Y0 = 160,
    parameter int DEFAULT_X1 = 440,
    parameter int DEFAULT_Y1 = 320,
    parameter int MIN_W      = 40,
    parameter int MIN_H      = 40
) (
    input  logic       clk_player_control,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x0,
    input  logic [9:0] cmd_y0,
    input  logic [9:0] cmd_x1,
    input  logic [9:0] cmd_y1,
    input  logic [2:0] cmd_gravity,
    input  logic [3:0] cmd_step,
    output logic [9:0] game_display_x0,
    output logic [9:0] game_display_y0,
    output logic [9:0] game_display_x1,
    output logic [9:0] game_display_y1,
    output logic [2:0] gravity_direction,
    output logic       busy,
    output logic       done,
    output logic       cmd_error
);

    typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [9:0]  edge_reg   [4];
    logic [9:0]  target_reg [4];
    logic [9:0]  edge_next  [4];
    logic [9:0]  cmd_edge   [4];
    logic [3:0]  reached;
    logic [3:0]  step_reg;
    logic [2:0]  gravity_latch_reg;
    logic [2:0]  gravity_reg;
    logic        error_reg;
    logic        cmd_legal;
    logic        accept;
    logic        reject;

    assign cmd_edge[0] = cmd_x0;
    assign cmd_edge[1] = cmd_y0;
    assign cmd_edge[2] = cmd_x1;
    assign cmd_edge[3] = cmd_y1;

    // Widened to 11 bits so x0 + MIN_W cannot wrap near the top of the 10-bit range.
    assign cmd_legal = ({1'b0, cmd_x1} >= ({1'b0, cmd_x0} + 11'(MIN_W)))
                    && ({1'b0, cmd_y1} >= ({1'b0, cmd_y0} + 11'(MIN_H)))
                    && (cmd_x1 <= 10'd639)
                    && (cmd_y1 <= 10'd479)
                    && (cmd_gravity <= 3'd4);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            localparam int DEF = (gi == 0) ? DEFAULT_X0 : (gi == 1) ? DEFAULT_Y0 :
                                 (gi == 2) ? DEFAULT_X1 : DEFAULT_Y1;

            // Distance is taken before any subtraction from the current edge, so no wrap.
            always_comb begin
                edge_next[gi] = edge_reg[gi];
                if (edge_reg[gi] < target_reg[gi]) begin
                    if ((target_reg[gi] - edge_reg[gi]) > {6'd0, step_reg})
                        edge_next[gi] = edge_reg[gi] + {6'd0, step_reg};
                    else
                        edge_next[gi] = target_reg[gi];
                end else if (edge_reg[gi] > target_reg[gi]) begin
                    if ((edge_reg[gi] - target_reg[gi]) > {6'd0, step_reg})
                        edge_next[gi] = edge_reg[gi] - {6'd0, step_reg};
                    else
                        edge_next[gi] = target_reg[gi];
                end
            end

            assign reached[gi] = (edge_next[gi] == target_reg[gi]);

            always_ff @(posedge clk_player_control) begin
                if (!reset_n) begin
                    edge_reg[gi]   <= 10'(DEF);
                    target_reg[gi] <= 10'(DEF);
                end else begin
                    if (accept)
                        target_reg[gi] <= cmd_edge[gi];
                    if (state_reg == MOVE)
                        edge_reg[gi] <= edge_next[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal) begin
                        accept     = 1'b1;
                        state_next = MOVE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            MOVE:    if (&reached) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_player_control) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            step_reg          <= 4'd1;
            gravity_latch_reg <= 3'd0;
            gravity_reg       <= 3'd0;
            error_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;
            error_reg <= reject;
            if (accept) begin
                step_reg          <= (cmd_step == 4'd0) ? 4'd1 : cmd_step;
                gravity_latch_reg <= cmd_gravity;
                gravity_reg       <= 3'd0;
            end
            if (state_reg == DONE)
                gravity_reg <= gravity_latch_reg;
        end
    end

    assign game_display_x0   = edge_reg[0];
    assign game_display_y0   = edge_reg[1];
    assign game_display_x1   = edge_reg[2];
    assign game_display_y1   = edge_reg[3];
    assign gravity_direction = gravity_reg;
    assign cmd_ready         = (state_reg == IDLE);
    assign busy              = (state_reg == MOVE);
    assign done              = (state_reg == DONE);
    assign cmd_error         = error_reg;

endmodule

// File: tb/tb_arena_transition_controller.sv
// Scoreboard bench for arena_transition_controller: a driver queues expected outcomes,
// a negedge monitor checks every MOVE cycle, done pulse and error pulse against them.
module tb_arena_transition_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [2:0] cmd_gravity = '0;
    logic [3:0] cmd_step = '0;
    logic [9:0] gx0, gy0, gx1, gy1;
    logic [2:0] gravity_direction;
    logic       busy, done, cmd_error;

    always #5 clk = ~clk;

    arena_transition_controller dut (
        .clk_player_control(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0),
        .cmd_y0(cmd_y0),
        .cmd_x1(cmd_x1),
        .cmd_y1(cmd_y1),
        .cmd_gravity(cmd_gravity),
        .cmd_step(cmd_step),
        .game_display_x0(gx0),
        .game_display_y0(gy0),
        .game_display_x1(gx1),
        .game_display_y1(gy1),
        .gravity_direction(gravity_direction),
        .busy(busy),
        .done(done),
        .cmd_error(cmd_error)
    );

    typedef struct {
        bit is_err;
        int s0, s1, s2, s3;
        int t0, t1, t2, t3;
        int step;
        int grav;
        int prev_grav;
        int cycles;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int mx0 = 200, my0 = 160, mx1 = 440, my1 = 320, mgrav = 0;
    bit hold = 1'b1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int edge_at(input int s, input int t, input int n, input int st);
        int d = (t > s) ? t - s : s - t;
        int m = (n * st < d) ? n * st : d;
        return (t > s) ? s + m : s - m;
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference: legality rules, effective step, and ceil(max distance / step) with a floor of 1.
    function automatic void model_push(input int x0, input int y0, input int x1, input int y1,
                                       input int g, input int st);
        exp_t e;
        int md;
        e.is_err = (x1 < x0 + 40) || (y1 < y0 + 40) || (x1 > 639) || (y1 > 479) || (g > 4);
        e.s0 = mx0; e.s1 = my0; e.s2 = mx1; e.s3 = my1;
        e.t0 = x0; e.t1 = y0; e.t2 = x1; e.t3 = y1;
        e.step = (st == 0) ? 1 : st;
        e.grav = g;
        e.prev_grav = mgrav;
        md = absd(x0, mx0);
        if (absd(y0, my0) > md) md = absd(y0, my0);
        if (absd(x1, mx1) > md) md = absd(x1, mx1);
        if (absd(y1, my1) > md) md = absd(y1, my1);
        e.cycles = (md + e.step - 1) / e.step;
        if (e.cycles == 0) e.cycles = 1;
        if (!e.is_err) begin
            mx0 = x0; my0 = y0; mx1 = x1; my1 = y1; mgrav = g;
        end
        q.push_back(e);
        $display("cmd %0d/%0d/%0d/%0d g=%0d step=%0d -> %s cycles=%0d",
                 x0, y0, x1, y1, g, st, e.is_err ? "reject" : "accept", e.cycles);
    endfunction

    task automatic drive(input int x0, input int y0, input int x1, input int y1,
                         input int g, input int st);
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
        cmd_gravity = 3'(g); cmd_step = 4'(st);
        cmd_valid = 1'b1;
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input int g, input int st);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        drive(x0, y0, x1, y1, g, st);
        @(posedge clk);
        model_push(x0, y0, x1, y1, g, st);
        #1 cmd_valid = 1'b0;
    endtask

    // Monitor state
    bit   active = 1'b0;
    bit   gpend = 1'b0;
    int   k = 0;
    int   gexp = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!reset_n || hold) begin
            active = 1'b0;
            gpend = 1'b0;
        end else begin
            if (busy) begin
                if (!active) begin
                    if (q.size() == 0 || q[0].is_err) begin
                        chk("unexpected_busy", 1, 0);
                    end else begin
                        cur = q.pop_front();
                        active = 1'b1;
                        k = 0;
                    end
                end
                if (active) begin
                    k++;
                    chk("move_x0", int'(gx0), edge_at(cur.s0, cur.t0, k - 1, cur.step));
                    chk("move_y0", int'(gy0), edge_at(cur.s1, cur.t1, k - 1, cur.step));
                    chk("move_x1", int'(gx1), edge_at(cur.s2, cur.t2, k - 1, cur.step));
                    chk("move_y1", int'(gy1), edge_at(cur.s3, cur.t3, k - 1, cur.step));
                    chk("move_gravity_zero", int'(gravity_direction), 0);
                end
            end
            if (done) begin
                if (!active) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("move_cycles", k, cur.cycles);
                    chk("done_box", int'(gx0) + 1000 * int'(gx1), cur.t0 + 1000 * cur.t2);
                    chk("done_box_y", int'(gy0) + 1000 * int'(gy1), cur.t1 + 1000 * cur.t3);
                    chk("done_busy", int'(busy), 0);
                    $display("done after %0d move cycles box %0d/%0d/%0d/%0d", k, gx0, gy0, gx1, gy1);
                    active = 1'b0;
                    gpend = 1'b1;
                    gexp = cur.grav;
                end
            end else if (gpend) begin
                chk("gravity_after_done", int'(gravity_direction), gexp);
                chk("ready_after_done", int'(cmd_ready), 1);
                gpend = 1'b0;
            end
            if (cmd_error) begin
                if (q.size() == 0 || !q[0].is_err) begin
                    chk("unexpected_error", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("err_box", int'(gx0) + 1000 * int'(gx1), cur.s0 + 1000 * cur.s2);
                    chk("err_box_y", int'(gy0) + 1000 * int'(gy1), cur.s1 + 1000 * cur.s3);
                    chk("err_gravity", int'(gravity_direction), cur.prev_grav);
                    chk("err_ready", int'(cmd_ready), 1);
                    $display("reject seen box %0d/%0d/%0d/%0d", gx0, gy0, gx1, gy1);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || active || gpend || !cmd_ready) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 0, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n;
        bit prev_done;
        int x0, y0, x1, y1;

        // Reset held two cycles
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x0", int'(gx0), 200);
        chk("rst_y0", int'(gy0), 160);
        chk("rst_x1", int'(gx1), 440);
        chk("rst_y1", int'(gy1), 320);
        chk("rst_gravity", int'(gravity_direction), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_err", int'(done) + int'(cmd_error), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        hold = 1'b0;

        send_cmd(180, 160, 440, 320, 3, 4);
        send_cmd(250, 200, 300, 300, 2, 15);
        send_cmd(250, 200, 300, 300, 1, 0);
        send_cmd(300, 200, 320, 300, 4, 2);
        send_cmd(100, 100, 300, 300, 7, 1);
        send_cmd(100, 100, 300, 480, 1, 1);
        wait_idle();

        // Second command held through a transition
        send_cmd(100, 100, 300, 300, 2, 3);
        drive(120, 110, 400, 400, 4, 5);
        prev_done = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            prev_done = done;
            @(negedge clk);
            n++;
        end
        chk("held_accept_after_done", int'(prev_done), 1);
        @(posedge clk);
        model_push(120, 110, 400, 400, 4, 5);
        #1 cmd_valid = 1'b0;
        wait_idle();

        // Reset during the third MOVE cycle
        hold = 1'b1;
        send_cmd(200, 160, 440, 320, 5 - 4, 1);
        n = 0;
        k = 0;
        while (n < 3 && k < 20) begin
            @(negedge clk);
            if (busy) n++;
            chk("no_done_before_reset", int'(done), 0);
            k++;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_x0", int'(gx0), 200);
        chk("midreset_x1y0", int'(gx1) + 1000 * int'(gy0), 440 + 160000);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_gravity", int'(gravity_direction), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        q.delete();
        mx0 = 200; my0 = 160; mx1 = 440; my1 = 320; mgrav = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_no_done", int'(done), 0);
        end
        chk("post_reset_ready", int'(cmd_ready), 1);
        hold = 1'b0;

        for (int i = 0; i < 25; i++) begin
            x0 = $urandom_range(0, 560);
            y0 = $urandom_range(0, 400);
            x1 = x0 + $urandom_range(30, 160);
            y1 = y0 + $urandom_range(30, 120);
            send_cmd(x0, y0, x1, y1, $urandom_range(0, 5), $urandom_range(0, 15));
        end
        wait_idle();
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
